seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed multi-digit 7-segment display driver. It latches a packed hexadecimal value and scans it across DIGITS common-anode digits, one digit per refresh period. Outputs are active-low segment, decimal-point and anode lines, registered on every cycle. It sits between the vending-machine datapath (credit, price and change values) and the board's 7-segment bank, and generalises the single-digit hex decoder to N digits with its own scan timing.

## Interface
- DIGITS, 4: number of digits scanned; must be ≥1.
- REFRESH_DIV, 100000: clk cycles each digit is displayed; must be ≥1. The prescaler width is $clog2(REFRESH_DIV), with a minimum of 1.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  display enable; when low, the display is dark and scanning is frozen.
- load  input  1  single-cycle strobe that captures value and dp_in.
- value  input  4*DIGITS  packed nibbles; nibble k (bits 4k+3:4k) drives digit k; digit 0 is the least significant.
- dp_in  input  DIGITS  per-digit decimal-point request; bit k maps to digit k; active-high.
- seg_n  output  7  segments {a,b,c,d,e,f,g} as bits 6..0; active-low.
- dp_n  output  1  decimal point; active-low.
- an_n  output  DIGITS  digit anodes; active-low, one-hot when enabled.
- digit_tick  output  1  one-cycle pulse when the scan index advances.

## Operation
- Hold registers value_q and dp_q:
  - reset to 0;
  - loaded from value and dp_in on the clk edge where load=1, regardless of en.
- Prescaler pre (0..REFRESH_DIV-1):
  - increments when en=1;
  - at REFRESH_DIV-1 it wraps to 0, and idx advances;
  - idx wraps from DIGITS-1 to 0.
  - When en=0, pre and idx hold their values.
- digit_tick is registered: it is 1 in the cycle after the wrap edge of pre, otherwise 0.
- Decode of nibble value_q[idx] to seg (bit6=a … bit0=g, 0 = lit):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Output registers, updated every cycle:
  - when en=1: an_n = ~(1<<idx), seg_n = decode, dp_n = ~dp_q[idx];
  - when en=0: an_n = all 1s, seg_n = 7'b1111111, dp_n = 1.
- No combinational path exists from any input to any output.

## Timing
- Reset values:
  - seg_n=7'b1111111, dp_n=1, an_n=all 1s, digit_tick=0;
  - idx=0, pre=0, value_q=0, dp_q=0.
  - First enabled cycle after reset: outputs show digit 0 (an_n=…1110, seg_n=0000001).
- Latency from a load strobe:
  - load sampled at edge t updates value_q at t;
  - outputs reflect the new value at edge t+1, for the digit currently indexed.
- Latency from en:
  - en rising at edge t gives driven outputs at t;
  - en falling at edge t gives blanked outputs at t;
  - pre and idx resume from their held values.
- Scan rate: each digit is active for exactly REFRESH_DIV cycles. A full frame is DIGITS*REFRESH_DIV cycles.
- REFRESH_DIV=1: idx advances every enabled cycle, and digit_tick is constantly 1 while en=1.
- DIGITS=1: idx stays 0, and digit_tick still pulses every REFRESH_DIV cycles.
- load and an idx advance on the same edge: both take effect; the new digit shows the new value.
- rst asserted mid-frame: on the next edge all state returns to its reset values, and any pending load is discarded. rst has priority over load and en.

## Configuration
- LEADING_ZERO_BLANK_EN: when defined, leading zeros are suppressed.
  - Digit k is blanked (seg_n=7'b1111111) when value_q nibbles k..DIGITS-1 are all 0 and k≠0.
  - Digit 0 is never blanked.
  - an_n and dp_n behave as normal for a blanked digit, so brightness duty stays uniform.
- Without the macro, every digit shows its nibble, including leading zeros.

## Test plan
- Reset and enable: DIGITS=4, REFRESH_DIV=4, rst high for 2 cycles, then en=1 with value=0 → after rst, an_n=1110 and seg_n=0000001; an_n steps 1101, 1011, 0111 every 4 cycles, then wraps to 1110; digit_tick pulses once per step.
- Decode sweep: load value=16'h3210, then 16'h7654, 16'hBA98 and 16'hFEDC, scanning one frame each → seg_n on every digit matches all 16 codes in the decode list.
- Enable freeze: en dropped for 10 cycles at pre=2, idx=1 → outputs blank (1111111/1/1111) and digit_tick=0; on resume, digit 1 completes its remaining 2 cycles before idx=2.
- Load mid-scan with decimal point: while idx=2, load value=16'h0A00 with dp_in=4'b0100 → on the next edge seg_n=0001000 and dp_n=0 on an_n=1011; the other digits show 0000001 with dp_n=1.
- LEADING_ZERO_BLANK_EN defined, value=16'h0050 → digits 3 and 2 show seg_n=1111111, digit 1 shows 0100100, digit 0 shows 0000001; with value=0, only digit 0 is lit.
- Reset mid-frame: rst pulsed at idx=3 coincident with load=1 → next cycle idx=0, outputs dark, value_q=0; the load is ignored.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed DIGITS-digit common-anode 7-segment driver.
// Latches a packed hex value and scans one digit per REFRESH_DIV clocks.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   en               display enable; low blanks outputs and freezes the scan
//   load             strobe capturing value / dp_in into hold registers
//   value, dp_in     packed nibbles (digit 0 = LSN) and per-digit decimal points
//   seg_n, dp_n      active-low segments {a..g} and decimal point
//   an_n             active-low one-hot digit anodes
//   digit_tick       one-cycle pulse when the scan index advances
module seg7_scan_driver #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  digit_tick
);

    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * DIGITS;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [VAL_W-1:0]  value_q;
    logic [DIGITS-1:0] dp_q;
    logic [PRE_W-1:0]  pre;
    logic [IDX_W-1:0]  idx;

    logic [3:0] nib_c;
    logic [6:0] seg_c;
    logic       dp_sel_c;

    // Hex nibble to active-low segment pattern, bit6=a .. bit0=g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Select and decode the currently indexed digit.
    always_comb begin
        nib_c    = 4'(value_q >> {idx, 2'b00});
        dp_sel_c = 1'(dp_q >> idx);
        seg_c    = hex_to_seg(nib_c);
`ifdef LEADING_ZERO_BLANK_EN
        // Blank when this nibble and every more-significant one are zero.
        if ((idx != '0) && ((value_q >> {idx, 2'b00}) == '0)) begin
            seg_c = 7'b1111111;
        end
`endif
    end

    // Hold registers, prescaler/scan index and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q    <= '0;
            dp_q       <= '0;
            pre        <= '0;
            idx        <= '0;
            seg_n      <= 7'b1111111;
            dp_n       <= 1'b1;
            an_n       <= '1;
            digit_tick <= 1'b0;
        end else begin
            if (load) begin
                value_q <= value;
                dp_q    <= dp_in;
            end
            digit_tick <= 1'b0;
            if (en) begin
                if (pre == PRE_MAX) begin
                    pre        <= '0;
                    idx        <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
                    digit_tick <= 1'b1;
                end else begin
                    pre <= pre + 1'b1;
                end
                // Outputs reflect the pre-edge index and hold registers.
                an_n  <= ~(DIGITS'(1) << idx);
                seg_n <= seg_c;
                dp_n  <= ~dp_sel_c;
            end else begin
                an_n  <= '1;
                seg_n <= 7'b1111111;
                dp_n  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4 plus a REFRESH_DIV=1 copy).
module tb_seg7_scan_driver;

    localparam int unsigned D = 4;
    localparam int unsigned R = 4;

    logic        clk = 1'b0;
    logic        rst, en, load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg_n,  seg1;
    logic        dp_n,   dp1;
    logic [3:0]  an_n,   an1;
    logic        digit_tick, tick1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(R)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
        .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .digit_tick(digit_tick));

    seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
        .seg_n(seg1), .dp_n(dp1), .an_n(an1), .digit_tick(tick1));

    logic [6:0] lut [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Model: enabled-cycle count since reset plus held value; snapshot is pre-edge state.
    int          ec = 0;
    logic [15:0] vq = '0;
    logic [3:0]  dq = '0;
    bit          s_valid = 0;
    bit          s_rst, s_en;
    int          s_ec;
    logic [15:0] s_vq;
    logic [3:0]  s_dq;

    always @(posedge clk) begin
        s_valid = 1;
        s_rst = rst; s_en = en; s_ec = ec; s_vq = vq; s_dq = dq;
        if (rst) begin
            ec = 0; vq = '0; dq = '0;
        end else begin
            if (en) ec = ec + 1;
            if (load) begin vq = value; dq = dp_in; end
        end
    end

    task automatic expect_for(input int r, output logic [6:0] s, output logic d,
                              output logic [3:0] a, output logic t);
        int i;
        s = 7'h7f; d = 1'b1; a = 4'hf; t = 1'b0;
        if (!s_rst && s_en) begin
            i = (s_ec / r) % D;
            s = lut[4'(s_vq >> (4 * i))];
            d = ~s_dq[i];
            a = ~(4'(1) << i);
            t = ((s_ec % r) == r - 1);
`ifdef LEADING_ZERO_BLANK_EN
            if (i != 0 && (s_vq >> (4 * i)) == 16'h0) s = 7'h7f;
`endif
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model for both instances.
    always @(negedge clk) begin
        logic [6:0] s; logic d; logic [3:0] a; logic t;
        if (s_valid) begin
            expect_for(R, s, d, a, t);
            check("seg_n", 32'(seg_n), 32'(s));
            check("dp_n", 32'(dp_n), 32'(d));
            check("an_n", 32'(an_n), 32'(a));
            check("digit_tick", 32'(digit_tick), 32'(t));
            expect_for(1, s, d, a, t);
            check("r1_seg_n", 32'(seg1), 32'(s));
            check("r1_dp_n", 32'(dp1), 32'(d));
            check("r1_an_n", 32'(an1), 32'(a));
            check("r1_tick", 32'(tick1), 32'(t));
        end
    end

    // Advance at negedges until the scan position (ec mod frame) matches.
    task automatic wait_pos(input int target);
        bit found = 0;
        for (int k = 0; k < 64 && !found; k++) begin
            if ((ec % (D * R)) == target) found = 1;
            else @(negedge clk);
        end
        check("wait_pos_timeout", 32'(found), 32'd1);
    endtask

    initial begin
        logic [15:0] sweep [4];
        sweep = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        rst = 1'b1; en = 1'b0; load = 1'b0; value = '0; dp_in = '0;
        repeat (2) @(negedge clk);
        check("rst_an", 32'(an_n), 32'hf);
        check("rst_seg", 32'(seg_n), 32'h7f);

        // First enabled cycle shows digit 0; tick when the index steps.
        rst = 1'b0; en = 1'b1;
        @(negedge clk);
        check("first_an", 32'(an_n), 32'b1110);
        check("first_seg", 32'(seg_n), 32'b0000001);
        repeat (3) @(negedge clk);
        check("step_tick", 32'(digit_tick), 32'd1);
        check("step_an_hold", 32'(an_n), 32'b1110);
        @(negedge clk);
        check("step_an", 32'(an_n), 32'b1101);
        repeat (12) @(negedge clk);

        // Decode sweep: one frame per value.
        for (int v = 0; v < 4; v++) begin
            load = 1'b1; value = sweep[v];
            @(negedge clk);
            load = 1'b0;
            repeat (D * R) @(negedge clk);
        end

        // Freeze at idx=1, pre=2 for 10 cycles.
        wait_pos(6);
        en = 1'b0;
        @(negedge clk);
        check("frz_an", 32'(an_n), 32'hf);
        check("frz_seg", 32'(seg_n), 32'h7f);
        check("frz_tick", 32'(digit_tick), 32'd0);
        repeat (9) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("resume_an1", 32'(an_n), 32'b1101);
        @(negedge clk);
        check("resume_an2", 32'(an_n), 32'b1101);
        check("resume_tick", 32'(digit_tick), 32'd1);
        @(negedge clk);
        check("resume_an3", 32'(an_n), 32'b1011);

        // Load mid-scan while idx=2, with a decimal point on digit 2.
        wait_pos(8);
        load = 1'b1; value = 16'h0A00; dp_in = 4'b0100;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        check("ld_seg", 32'(seg_n), 32'b0001000);
        check("ld_dp", 32'(dp_n), 32'd0);
        check("ld_an", 32'(an_n), 32'b1011);
        repeat (D * R) @(negedge clk);

        // Randomized enable and load traffic.
        repeat (400) begin
            en    = ($urandom_range(0, 9) != 0);
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom);
            dp_in = 4'($urandom);
            @(negedge clk);
        end
        en = 1'b1; load = 1'b0;

        // Reset at idx=3 coincident with a load: load is discarded.
        wait_pos(12);
        rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp_in = 4'hf;
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        check("mrst_an", 32'(an_n), 32'hf);
        check("mrst_seg", 32'(seg_n), 32'h7f);
        check("mrst_tick", 32'(digit_tick), 32'd0);
        @(negedge clk);
        check("mrst_an0", 32'(an_n), 32'b1110);
        check("mrst_seg0", 32'(seg_n), 32'b0000001);
        check("mrst_dp0", 32'(dp_n), 32'd1);
        repeat (D * R) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
